// File: rtl/corr_accum_dump_if.sv
// Result channel of the correlator accumulator: dumped I/Q sums plus a
// valid/ready handshake towards the downstream consumer.
interface corr_accum_dump_if #(
   parameter int NUM_ACCUM = 4,
   parameter int ACC_W     = 16
);
   logic [NUM_ACCUM*ACC_W-1:0] acc_re_out;
   logic [NUM_ACCUM*ACC_W-1:0] acc_im_out;
   logic                       out_valid;
   logic                       out_ready;

   // Producer side (the accumulator)
   modport master (
      output acc_re_out,
      output acc_im_out,
      output out_valid,
      input  out_ready
   );

   // Consumer side
   modport slave (
      input  acc_re_out,
      input  acc_im_out,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/corr_accum_dump.sv
// Multi-lane complex correlator accumulator with epoch dump.
// Each lane decodes 2-bit sign/magnitude I and Q samples, wipes them off
// with a +/-1 replica bit, and integrates into saturating accumulators.
// A dump strobe moves the epoch sums into a one-deep output register that
// is drained through a valid/ready handshake; overwriting an unaccepted
// result raises a sticky overrun flag.
module corr_accum_dump #(
   parameter int NUM_ACCUM = 4,
   parameter int ACC_W     = 16
) (
   input  logic                   pclk,
   input  logic                   reset_n,
   input  logic [2*NUM_ACCUM-1:0] signal_in_re,
   input  logic [2*NUM_ACCUM-1:0] signal_in_im,
   input  logic [NUM_ACCUM-1:0]   ref_in,
   input  logic                   acc_en,
   input  logic                   dump,
   input  logic                   ovr_clr,
   output logic                   overrun,
   corr_accum_dump_if.master      res
);

   localparam int SUM_W = ACC_W + 1;
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   typedef enum logic {ST_EMPTY, ST_FULL} state_t;

   // bit1 = sign, bit0 = magnitude (1 -> 3, 0 -> 1); replica bit 1 negates
   function automatic logic signed [2:0] decode(input logic [1:0] s, input logic r);
      logic signed [2:0] mag;
      mag = s[0] ? 3'sd3 : 3'sd1;
      return (s[1] ^ r) ? -mag : mag;
   endfunction

   // One guard bit is enough for a +/-3 step; disagreeing top bits mean overflow
   function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [2:0]       p);
      logic [SUM_W-1:0] s;
      s = {a[ACC_W-1], a} + {{(SUM_W-3){p[2]}}, p};
      if (s[SUM_W-1] != s[SUM_W-2])
         return s[SUM_W-1] ? ACC_MIN : ACC_MAX;
      else
         return s[ACC_W-1:0];
   endfunction

   logic signed [ACC_W-1:0]    r_acc_re_p0 [NUM_ACCUM];
   logic signed [ACC_W-1:0]    r_acc_im_p0 [NUM_ACCUM];
   logic signed [ACC_W-1:0]    w_sum_re    [NUM_ACCUM];
   logic signed [ACC_W-1:0]    w_sum_im    [NUM_ACCUM];
   logic [NUM_ACCUM*ACC_W-1:0] w_dump_re;
   logic [NUM_ACCUM*ACC_W-1:0] w_dump_im;
   logic [NUM_ACCUM*ACC_W-1:0] r_out_re_p1;
   logic [NUM_ACCUM*ACC_W-1:0] r_out_im_p1;
   state_t                     r_state;
   state_t                     w_state_nxt;
   logic                       w_ovr_set;
   logic                       r_overrun;

   // Per-lane product and saturated next sum; dump value skips the add when disabled
   always_comb begin
      w_sum_re  = '{default: '0};
      w_sum_im  = '{default: '0};
      w_dump_re = '0;
      w_dump_im = '0;
      for (int i = 0; i < NUM_ACCUM; i++) begin
         w_sum_re[i] = sat_add(r_acc_re_p0[i], decode(signal_in_re[2*i +: 2], ref_in[i]));
         w_sum_im[i] = sat_add(r_acc_im_p0[i], decode(signal_in_im[2*i +: 2], ref_in[i]));
         w_dump_re[i*ACC_W +: ACC_W] = acc_en ? w_sum_re[i] : r_acc_re_p0[i];
         w_dump_im[i*ACC_W +: ACC_W] = acc_en ? w_sum_im[i] : r_acc_im_p0[i];
      end
   end

   // ---- stage p0: epoch accumulators, restart from zero on dump ----
   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_ACCUM; i++) begin
            r_acc_re_p0[i] <= '0;
            r_acc_im_p0[i] <= '0;
         end
      end else if (dump) begin
         for (int i = 0; i < NUM_ACCUM; i++) begin
            r_acc_re_p0[i] <= '0;
            r_acc_im_p0[i] <= '0;
         end
      end else if (acc_en) begin
         for (int i = 0; i < NUM_ACCUM; i++) begin
            r_acc_re_p0[i] <= w_sum_re[i];
            r_acc_im_p0[i] <= w_sum_im[i];
         end
      end
   end

   // ---- stage p1: dumped result register, only loaded by a dump ----
   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         r_out_re_p1 <= '0;
         r_out_im_p1 <= '0;
      end else if (dump) begin
         r_out_re_p1 <= w_dump_re;
         r_out_im_p1 <= w_dump_im;
      end
   end

   // Output-slot state register
   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_EMPTY;
      else          r_state <= w_state_nxt;
   end

   // Slot next state; a dump onto an unaccepted result flags an overrun
   always_comb begin
      w_state_nxt = r_state;
      w_ovr_set   = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (dump) w_state_nxt = ST_FULL;
         end
         ST_FULL: begin
            if (dump) begin
               w_state_nxt = ST_FULL;
               w_ovr_set   = !res.out_ready;
            end else if (res.out_ready) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   // Sticky overrun; a new overrun event takes priority over the clear
   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n)       r_overrun <= 1'b0;
      else if (w_ovr_set) r_overrun <= 1'b1;
      else if (ovr_clr)   r_overrun <= 1'b0;
   end

   assign res.acc_re_out = r_out_re_p1;
   assign res.acc_im_out = r_out_im_p1;
   assign res.out_valid  = (r_state == ST_FULL);
   assign overrun        = r_overrun;

endmodule

// File: tb/tb_corr_accum_dump.sv
// Directed bench for corr_accum_dump with a result scoreboard.
module tb_corr_accum_dump;
   localparam int NA = 2;
   localparam int AW = 8;

   typedef struct {
      logic [NA*AW-1:0] re;
      logic [NA*AW-1:0] im;
   } res_t;

   logic            pclk = 1'b0;
   logic            reset_n;
   logic [2*NA-1:0] s_re, s_im;
   logic [NA-1:0]   rf;
   logic            acc_en, dump, ovr_clr, overrun;

   int   n_total = 0, n_pass = 0, n_fail = 0;
   int   m_re[NA], m_im[NA], mo_re[NA], mo_im[NA];
   bit   m_valid, m_ovr;
   res_t sb[$];

   corr_accum_dump_if #(.NUM_ACCUM(NA), .ACC_W(AW)) res_if ();

   corr_accum_dump #(.NUM_ACCUM(NA), .ACC_W(AW)) dut (
      .pclk         (pclk),
      .reset_n      (reset_n),
      .signal_in_re (s_re),
      .signal_in_im (s_im),
      .ref_in       (rf),
      .acc_en       (acc_en),
      .dump         (dump),
      .ovr_clr      (ovr_clr),
      .overrun      (overrun),
      .res          (res_if)
   );

   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass = n_pass + 1;
      else begin
         n_fail = n_fail + 1;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic signed [31:0] lane(input logic [NA*AW-1:0] v, input int i);
      logic signed [AW-1:0] t;
      t = v[i*AW +: AW];
      return t;
   endfunction

   function automatic int dec(input logic [1:0] s, input logic r);
      int mag;
      mag = s[0] ? 3 : 1;
      return (s[1] ^ r) ? -mag : mag;
   endfunction

   function automatic int sat(input int v);
      if (v > 127)  return 127;
      if (v < -128) return -128;
      return v;
   endfunction

   // Drive one cycle, advance the model, then check at the following negedge
   task automatic step(input logic [3:0] re, input logic [3:0] im, input logic [1:0] r,
                       input logic en, input logic d, input logic rdy, input logic clr);
      bit   ovr_set;
      int   sr, si;
      res_t e;
      res_t got;
      s_re = re; s_im = im; rf = r; acc_en = en; dump = d;
      res_if.out_ready = rdy; ovr_clr = clr;
      ovr_set = d && m_valid && !rdy;
      for (int i = 0; i < NA; i++) begin
         sr = sat(m_re[i] + dec(re[2*i +: 2], r[i]));
         si = sat(m_im[i] + dec(im[2*i +: 2], r[i]));
         if (d) begin
            mo_re[i] = en ? sr : m_re[i];
            mo_im[i] = en ? si : m_im[i];
            m_re[i] = 0; m_im[i] = 0;
         end else if (en) begin
            m_re[i] = sr; m_im[i] = si;
         end
      end
      if (d) begin
         for (int i = 0; i < NA; i++) begin
            e.re[i*AW +: AW] = mo_re[i][AW-1:0];
            e.im[i*AW +: AW] = mo_im[i][AW-1:0];
         end
         sb.push_back(e);
      end
      m_ovr   = ovr_set ? 1'b1 : (clr ? 1'b0 : m_ovr);
      m_valid = d ? 1'b1 : (rdy ? 1'b0 : m_valid);
      @(negedge pclk);
      chk("out_valid", res_if.out_valid, m_valid);
      chk("overrun", overrun, m_ovr);
      if (d) begin
         if (sb.size() == 0) chk("sb_empty", 1, 0);
         else begin
            got = sb.pop_front();
            for (int i = 0; i < NA; i++) begin
               chk("dump_re", lane(res_if.acc_re_out, i), lane(got.re, i));
               chk("dump_im", lane(res_if.acc_im_out, i), lane(got.im, i));
            end
         end
      end else if (m_valid) begin
         for (int i = 0; i < NA; i++) begin
            chk("hold_re", lane(res_if.acc_re_out, i), mo_re[i]);
            chk("hold_im", lane(res_if.acc_im_out, i), mo_im[i]);
         end
      end
   endtask

   // n accumulation cycles, dump on the last one
   task automatic epoch(input int n, input logic [3:0] re, input logic [3:0] im,
                        input logic [1:0] r, input logic rdy_last, input logic clr_last);
      for (int k = 0; k < n; k++)
         step(re, im, r, 1'b1, k == n-1, (k == n-1) ? rdy_last : 1'b0, (k == n-1) ? clr_last : 1'b0);
   endtask

   task automatic model_reset();
      for (int i = 0; i < NA; i++) begin
         m_re[i] = 0; m_im[i] = 0; mo_re[i] = 0; mo_im[i] = 0;
      end
      m_valid = 0; m_ovr = 0;
      sb.delete();
   endtask

   initial begin
      s_re = '0; s_im = '0; rf = '0; acc_en = 0; dump = 0; ovr_clr = 0;
      res_if.out_ready = 0;
      reset_n = 1'b1;
      model_reset();
      #2 reset_n = 1'b0;
      @(negedge pclk);
      @(negedge pclk);
      chk("rst_valid", res_if.out_valid, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_re", res_if.acc_re_out, 0);
      chk("rst_im", res_if.acc_im_out, 0);
      reset_n = 1'b1;
      @(negedge pclk);

      // +3 on lane0, -3 on lane1 for 10 cycles
      epoch(10, 4'b1101, 4'b0000, 2'b00, 1'b0, 1'b0);
      chk("r031_re0", lane(res_if.acc_re_out, 0), 30);
      chk("r031_re1", lane(res_if.acc_re_out, 1), -30);
      chk("r031_im0", lane(res_if.acc_im_out, 0), 10);
      step(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("accept_valid", res_if.out_valid, 0);

      // Replica wipe-off: ref=1 flips the -3/+3 samples
      epoch(5, 4'b0000, 4'b0111, 2'b11, 1'b0, 1'b0);
      chk("r032_im0_pos", lane(res_if.acc_im_out, 0), 15);
      chk("r032_im1_neg", lane(res_if.acc_im_out, 1), -15);
      chk("r032_re0", lane(res_if.acc_re_out, 0), -5);

      // Dump and accept in the same cycle: no overrun, new data
      epoch(5, 4'b0000, 4'b0111, 2'b00, 1'b1, 1'b0);
      chk("r035_valid", res_if.out_valid, 1);
      chk("r035_overrun", overrun, 0);
      chk("r032_im0_neg", lane(res_if.acc_im_out, 0), -15);
      chk("r032_im1_pos", lane(res_if.acc_im_out, 1), 15);

      // Dump onto an unaccepted result
      epoch(2, 4'b0101, 4'b0000, 2'b00, 1'b0, 1'b0);
      chk("r034_overrun", overrun, 1);
      chk("r034_re0", lane(res_if.acc_re_out, 0), 6);
      step(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("r034_cleared", overrun, 0);
      // Overrun and clear together: set wins
      epoch(1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1);
      chk("set_wins", overrun, 1);
      step(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);

      // Saturation at both rails
      epoch(50, 4'b1101, 4'b0101, 2'b00, 1'b0, 1'b0);
      chk("r033_pos_sat", lane(res_if.acc_re_out, 0), 127);
      chk("r033_neg_sat", lane(res_if.acc_re_out, 1), -128);
      step(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);

      // Hold with acc_en=0, then dump without adding the dump-cycle sample
      for (int k = 0; k < 3; k++) step(4'b0001, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
      step(4'b0101, 4'b0101, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
      step(4'b0101, 4'b0101, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("hold_re0", lane(res_if.acc_re_out, 0), 9);
      chk("hold_re1", lane(res_if.acc_re_out, 1), 3);

      // Reset mid-epoch discards partial sums and the pending result
      for (int k = 0; k < 7; k++) step(4'b0101, 4'b0101, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
      #1 reset_n = 1'b0;
      #1;
      chk("r036_valid", res_if.out_valid, 0);
      chk("r036_overrun", overrun, 0);
      chk("r036_re", res_if.acc_re_out, 0);
      chk("r036_im", res_if.acc_im_out, 0);
      model_reset();
      @(negedge pclk);
      reset_n = 1'b1;
      epoch(3, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0);
      chk("r036_re0", lane(res_if.acc_re_out, 0), 3);
      chk("r036_im1", lane(res_if.acc_im_out, 1), 3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/corr_accum_dump.md
CORR_ACCUM_DUMP -- requirements
Module: corr_accum_dump

Interface
REQ-001 Parameter NUM_ACCUM, default 4, number of parallel 2-bit sample lanes (matches upstream signal mux bus width 2*NUM_ACCUM).
REQ-002 Parameter ACC_W, default 16, signed accumulator width per lane per component.
REQ-003 pclk  input  1  single clock; all logic on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 signal_in_re  input  2*NUM_ACCUM  registered real samples from signal mux; lane i = bits [2i+1:2i].
REQ-006 signal_in_im  input  2*NUM_ACCUM  registered imaginary samples, same lane layout.
REQ-007 ref_in  input  NUM_ACCUM  replica bit per lane; 0 = +1, 1 = -1.
REQ-008 acc_en  input  1  accumulate enable.
REQ-009 dump  input  1  one-cycle epoch strobe.
REQ-010 ovr_clr  input  1  clears overrun flag.
REQ-011 acc_re_out  output  NUM_ACCUM*ACC_W  dumped real sums; lane i = bits [(i+1)*ACC_W-1:i*ACC_W].
REQ-012 acc_im_out  output  NUM_ACCUM*ACC_W  dumped imaginary sums, same layout.
REQ-013 out_valid  output  1  dumped result pending.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 overrun  output  1  sticky: a pending result was overwritten.

Function
REQ-016 Sample decode per lane: bit1 = sign (1 negative), bit0 = magnitude (1 -> 3, 0 -> 1); values {+1,+3,-1,-3}.
REQ-017 Product per lane = decoded sample, negated when ref_in[i]=1; real and imaginary handled identically and independently.
REQ-018 When acc_en=1 and dump=0: each accumulator <= sat(acc + product); when acc_en=0 and dump=0: accumulators hold.
REQ-019 Saturation: sum clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; no wrap-around ever.
REQ-020 On dump=1: output registers <= sat(acc + product) if acc_en=1, else acc; all accumulators <= 0 in same cycle; out_valid <= 1 next cycle.
REQ-021 Latency: sample present at cycle N contributes to accumulator visible at N+1; dump at cycle N gives out_valid and data at N+1.
REQ-022 Handshake: transfer when out_valid=1 and out_ready=1 on a rising edge; out_valid then drops to 0 unless a dump occurs that same cycle.
REQ-023 Output data stable while out_valid=1 and no dump; out_ready ignored while out_valid=0.
REQ-024 Dump with out_valid=1 and out_ready=0: data overwritten, out_valid stays 1, overrun <= 1.
REQ-025 Dump with out_valid=1 and out_ready=1: old result accepted, new result loaded, out_valid stays 1, no overrun.
REQ-026 overrun cleared by ovr_clr=1; simultaneous overrun event and ovr_clr: overrun remains 1 (set wins).
REQ-027 Two-state control per output: EMPTY (out_valid=0) and FULL (out_valid=1); EMPTY->FULL on dump; FULL->EMPTY on out_ready without dump; FULL->FULL on dump.

Reset
REQ-028 reset_n=0 asynchronously forces all accumulators, acc_re_out, acc_im_out to 0 and out_valid, overrun to 0.
REQ-029 Reset mid-epoch discards partial sums; first epoch after release starts from 0.
REQ-030 Outputs are registered only; no combinational path from inputs to outputs.

Verification
REQ-031 NUM_ACCUM=1; acc_en=1, signal_in_re=2'b01, ref_in=0 for 10 cycles, dump on 10th -> acc_re_out=30, out_valid=1 next cycle.
REQ-032 signal_in_im=2'b11, ref_in=1 for 5 cycles then dump -> acc_im_out=+15; with ref_in=0 -> -15.
REQ-033 ACC_W=8, +3 input for 50 cycles then dump -> acc_re_out=127 (saturated, no wrap); -3 input -> -128.
REQ-034 Dump with out_ready=0 while out_valid=1 -> new data shown, out_valid=1, overrun=1; ovr_clr pulse -> overrun=0.
REQ-035 Dump and out_ready both high while out_valid=1 -> out_valid stays 1, overrun stays 0, new data shown.
REQ-036 reset_n pulsed low mid-epoch after 7 accumulations -> all outputs 0 immediately; next 3-cycle epoch of +1 dumps 3.
